pipeline_stall_ctrl: RTL and testbench

//  Central stall controller and divide sequencer for the 5-stage pipeline.
//  - Merges ID/EX/MEM stall requests into the stall bus that drives every pipeline buffer.
//  - Runs the handshake with the iterative divider.
//  - Holds EX until the quotient/remainder is latched, then releases the EX/MEM buffer for one capture cycle.

---
 rtl/pipeline_stall_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - pipeline stall bus merge and divide sequencer (optional watchdog: DIV_WATCHDOG_EN)
module pipeline_stall_ctrl #(
    parameter int STALL_WIDTH    = 6,
    parameter int DIV_CYCLES     = 32,
    parameter int WATCHDOG_SLACK = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   id_stall_request,
    input  logic                   ex_stall_request,
    input  logic                   mem_stall_request,
    input  logic                   ex_div_request,
    input  logic                   ex_div_signed,
    input  logic [31:0]            ex_div_opa,
    input  logic [31:0]            ex_div_opb,
    input  logic                   div_cancel,
    input  logic                   div_ready,
    input  logic [63:0]            div_result,
    output logic [STALL_WIDTH-1:0] stall,
    output logic                   div_start,
    output logic                   div_abort,
    output logic                   div_signed,
    output logic [31:0]            div_opa,
    output logic [31:0]            div_opb,
    output logic [63:0]            ex_div_result,
    output logic                   ex_div_valid,
    output logic                   div_error
);

    // Divide sequencer states.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Stall patterns: bit 0 = PC up to bit 5 = WB. A stage stall freezes itself and everything upstream.
    localparam logic [STALL_WIDTH-1:0] STALL_NONE = STALL_WIDTH'(6'b000000);
    localparam logic [STALL_WIDTH-1:0] STALL_ID   = STALL_WIDTH'(6'b000111);
    localparam logic [STALL_WIDTH-1:0] STALL_EX   = STALL_WIDTH'(6'b001111);
    localparam logic [STALL_WIDTH-1:0] STALL_MEM  = STALL_WIDTH'(6'b011111);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;

    logic        r_div_start;
    logic        r_div_abort;
    logic        r_div_signed;
    logic [31:0] r_div_opa;
    logic [31:0] r_div_opb;
    logic [63:0] r_ex_div_result;
    logic        r_ex_div_valid;

    logic        w_take_ops;
    logic        w_cancel_kill;
    logic        w_capture;
    logic        w_timeout;
    logic        w_div_busy;
    logic        w_in_flight;

    assign w_in_flight = (r_state == S_START) || (r_state == S_BUSY);

    // Load operands only when a new divide is accepted from IDLE.
    assign w_take_ops = (r_state == S_IDLE) && ex_div_request && !div_cancel;

    // A flush kills START/BUSY; it has no effect in IDLE and does not suppress a DONE cycle.
    assign w_cancel_kill = w_in_flight && div_cancel;

    // Flush takes priority over a ready pulse arriving in the same cycle.
    assign w_capture = (r_state == S_BUSY) && div_ready && !div_cancel;

`ifdef DIV_WATCHDOG_EN
    // Counter value during the last tolerated BUSY cycle; timing out there puts DONE
    // exactly DIV_CYCLES+WATCHDOG_SLACK BUSY cycles after START.
    localparam logic [5:0] WD_LIMIT = 6'(DIV_CYCLES + WATCHDOG_SLACK - 1);

    logic [5:0] r_wd_count;
    logic       r_div_error;

    assign w_timeout = (r_state == S_BUSY) && !div_cancel && !div_ready && (r_wd_count == WD_LIMIT);

    // Watchdog counter: cleared in START, counts BUSY cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wd_count <= 6'd0;
        end else if (r_state == S_START) begin
            r_wd_count <= 6'd0;
        end else if (r_state == S_BUSY) begin
            r_wd_count <= r_wd_count + 6'd1;
        end
    end

    // Error pulse accompanies the watchdog abort for one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_div_error <= 1'b0;
        end else begin
            r_div_error <= w_timeout;
        end
    end

    assign div_error = r_div_error;
`else
    // Without the watchdog BUSY waits for the divider indefinitely.
    assign w_timeout = 1'b0;
    assign div_error = 1'b0;
`endif

    // Next-state selection for the divide sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_take_ops) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (div_cancel) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (div_cancel) begin
                    w_next_state = S_IDLE;
                end else if (w_capture || w_timeout) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand and sign capture; held stable from START through DONE for the divider.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_div_signed <= 1'b0;
            r_div_opa    <= 32'd0;
            r_div_opb    <= 32'd0;
        end else if (w_take_ops) begin
            r_div_signed <= ex_div_signed;
            r_div_opa    <= ex_div_opa;
            r_div_opb    <= ex_div_opb;
        end
    end

    // div_start is high for exactly the START cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_div_start <= 1'b0;
        end else begin
            r_div_start <= w_take_ops;
        end
    end

    // Abort pulse on the cycle after a flush or watchdog expiry; a reset needs none.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_div_abort <= 1'b0;
        end else begin
            r_div_abort <= w_cancel_kill || w_timeout;
        end
    end

    // Result latch: divider result on ready, zero on watchdog expiry, otherwise held.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ex_div_result <= 64'd0;
        end else if (w_capture) begin
            r_ex_div_result <= div_result;
        end else if (w_timeout) begin
            r_ex_div_result <= 64'd0;
        end
    end

    // Valid tracks the DONE state exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ex_div_valid <= 1'b0;
        end else begin
            r_ex_div_valid <= (w_next_state == S_DONE);
        end
    end

    // EX is held for the whole divide except DONE, so the EX/MEM buffer captures the result once.
    assign w_div_busy = ex_div_request && (r_state != S_DONE);

    // Stall bus merge, downstream stages take priority.
    always_comb begin
        stall = STALL_NONE;
        if (mem_stall_request) begin
            stall = STALL_MEM;
        end else if (ex_stall_request || w_div_busy) begin
            stall = STALL_EX;
        end else if (id_stall_request) begin
            stall = STALL_ID;
        end
    end

    assign div_start     = r_div_start;
    assign div_abort     = r_div_abort;
    assign div_signed    = r_div_signed;
    assign div_opa       = r_div_opa;
    assign div_opb       = r_div_opb;
    assign ex_div_result = r_ex_div_result;
    assign ex_div_valid  = r_ex_div_valid;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed self-checking bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

    logic        clock;
    logic        reset;
    logic        id_stall_request;
    logic        ex_stall_request;
    logic        mem_stall_request;
    logic        ex_div_request;
    logic        ex_div_signed;
    logic [31:0] ex_div_opa;
    logic [31:0] ex_div_opb;
    logic        div_cancel;
    logic        div_ready;
    logic [63:0] div_result;
    logic [5:0]  stall;
    logic        div_start;
    logic        div_abort;
    logic        div_signed;
    logic [31:0] div_opa;
    logic [31:0] div_opb;
    logic [63:0] ex_div_result;
    logic        ex_div_valid;
    logic        div_error;

    int n_total = 0;
    int n_bad   = 0;

    pipeline_stall_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .id_stall_request  (id_stall_request),
        .ex_stall_request  (ex_stall_request),
        .mem_stall_request (mem_stall_request),
        .ex_div_request    (ex_div_request),
        .ex_div_signed     (ex_div_signed),
        .ex_div_opa        (ex_div_opa),
        .ex_div_opb        (ex_div_opb),
        .div_cancel        (div_cancel),
        .div_ready         (div_ready),
        .div_result        (div_result),
        .stall             (stall),
        .div_start         (div_start),
        .div_abort         (div_abort),
        .div_signed        (div_signed),
        .div_opa           (div_opa),
        .div_opb           (div_opb),
        .ex_div_result     (ex_div_result),
        .ex_div_valid      (ex_div_valid),
        .div_error         (div_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        id_stall_request  = 1'b0;
        ex_stall_request  = 1'b0;
        mem_stall_request = 1'b0;
        ex_div_request    = 1'b0;
        ex_div_signed     = 1'b0;
        ex_div_opa        = 32'd0;
        ex_div_opb        = 32'd0;
        div_cancel        = 1'b0;
        div_ready         = 1'b0;
        div_result        = 64'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        n_total++; if (stall !== 6'b000000) begin n_bad++; $display("FAIL reset_stall got=%b want=000000", stall); end
        n_total++; if (div_start !== 1'b0) begin n_bad++; $display("FAIL reset_start got=%b want=0", div_start); end
        n_total++; if (div_abort !== 1'b0) begin n_bad++; $display("FAIL reset_abort got=%b want=0", div_abort); end
        n_total++; if (div_signed !== 1'b0) begin n_bad++; $display("FAIL reset_signed got=%b want=0", div_signed); end
        n_total++; if ({div_opa, div_opb} !== 64'd0) begin n_bad++; $display("FAIL reset_ops got=%h want=0", {div_opa, div_opb}); end
        n_total++; if (ex_div_result !== 64'd0) begin n_bad++; $display("FAIL reset_result got=%h want=0", ex_div_result); end
        n_total++; if (ex_div_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", ex_div_valid); end
        n_total++; if (div_error !== 1'b0) begin n_bad++; $display("FAIL reset_error got=%b want=0", div_error); end
        id_stall_request = 1'b1;
        #1;
        n_total++; if (stall !== 6'b000111) begin n_bad++; $display("FAIL reset_comb_stall got=%b want=000111", stall); end
        id_stall_request = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_stall_merge();
        // {mem, ex, id} -> expected stall bus
        logic [2:0] req [8];
        logic [5:0] exp [8];
        req[0] = 3'b000; exp[0] = 6'b000000;
        req[1] = 3'b001; exp[1] = 6'b000111;
        req[2] = 3'b010; exp[2] = 6'b001111;
        req[3] = 3'b011; exp[3] = 6'b001111;
        req[4] = 3'b100; exp[4] = 6'b011111;
        req[5] = 3'b101; exp[5] = 6'b011111;
        req[6] = 3'b110; exp[6] = 6'b011111;
        req[7] = 3'b111; exp[7] = 6'b011111;
        for (int i = 0; i < 8; i++) begin
            {mem_stall_request, ex_stall_request, id_stall_request} = req[i];
            #1;
            n_total++; if (stall !== exp[i]) begin n_bad++; $display("FAIL stall_merge req=%b got=%b want=%b", req[i], stall, exp[i]); end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_divide();
        ex_div_request = 1'b1;
        ex_div_signed  = 1'b1;
        ex_div_opa     = 32'd100;
        ex_div_opb     = 32'd7;
        step();
        n_total++; if (div_start !== 1'b1) begin n_bad++; $display("FAIL div_start_pulse got=%b want=1", div_start); end
        n_total++; if ({div_signed, div_opa, div_opb} !== {1'b1, 32'd100, 32'd7}) begin n_bad++; $display("FAIL div_operands got=%b/%0d/%0d want=1/100/7", div_signed, div_opa, div_opb); end
        n_total++; if (stall !== 6'b001111) begin n_bad++; $display("FAIL div_start_stall got=%b want=001111", stall); end
        ex_div_opa = 32'd999;
        step();
        for (int i = 0; i < 31; i++) begin
            n_total++; if ({div_start, stall[3], ex_div_valid} !== 3'b010) begin n_bad++; $display("FAIL div_busy_%0d got start/stall3/valid=%b want=010", i, {div_start, stall[3], ex_div_valid}); end
            step();
        end
        n_total++; if (div_opa !== 32'd100) begin n_bad++; $display("FAIL div_opa_stable got=%0d want=100", div_opa); end
        div_ready  = 1'b1;
        div_result = {32'd2, 32'd14};
        step();
        div_ready  = 1'b0;
        div_result = 64'hdead_beef_dead_beef;
        #1;
        n_total++; if (ex_div_valid !== 1'b1) begin n_bad++; $display("FAIL div_done_valid got=%b want=1", ex_div_valid); end
        n_total++; if (ex_div_result !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL div_done_result got=%h want=%h", ex_div_result, {32'd2, 32'd14}); end
        n_total++; if (stall !== 6'b000000) begin n_bad++; $display("FAIL div_done_stall got=%b want=000000", stall); end
        ex_div_request = 1'b0;
        step();
        n_total++; if (ex_div_valid !== 1'b0) begin n_bad++; $display("FAIL div_after_done_valid got=%b want=0", ex_div_valid); end
        idle_inputs();
    endtask

    task automatic test_ready_ignored();
        div_ready  = 1'b1;
        div_result = 64'h1111_2222_3333_4444;
        step();
        div_ready = 1'b0;
        step();
        n_total++; if ({ex_div_valid, ex_div_result} !== {1'b0, 32'd2, 32'd14}) begin n_bad++; $display("FAIL ready_idle got=%b/%h want=0/%h", ex_div_valid, ex_div_result, {32'd2, 32'd14}); end
        idle_inputs();
    endtask

    task automatic test_cancel_busy();
        logic seen_valid;
        seen_valid = 1'b0;
        ex_div_request = 1'b1;
        ex_div_opa     = 32'd9;
        ex_div_opb     = 32'd3;
        step();
        step();
        repeat (4) step();
        div_cancel = 1'b1;
        step();
        div_cancel     = 1'b0;
        ex_div_request = 1'b0;
        #1;
        n_total++; if (div_abort !== 1'b1) begin n_bad++; $display("FAIL cancel_abort got=%b want=1", div_abort); end
        n_total++; if (stall !== 6'b000000) begin n_bad++; $display("FAIL cancel_stall got=%b want=000000", stall); end
        seen_valid = seen_valid | ex_div_valid;
        step();
        n_total++; if ({div_abort, div_start} !== 2'b00) begin n_bad++; $display("FAIL cancel_abort_once got=%b want=00", {div_abort, div_start}); end
        for (int i = 0; i < 3; i++) begin
            seen_valid = seen_valid | ex_div_valid;
            step();
        end
        n_total++; if (seen_valid !== 1'b0) begin n_bad++; $display("FAIL cancel_valid_seen got=%b want=0", seen_valid); end
        idle_inputs();
    endtask

    task automatic test_cancel_start();
        ex_div_request = 1'b1;
        step();
        div_cancel = 1'b1;
        step();
        div_cancel     = 1'b0;
        ex_div_request = 1'b0;
        #1;
        n_total++; if ({div_abort, div_start, ex_div_valid} !== 3'b100) begin n_bad++; $display("FAIL cancel_start got=%b want=100", {div_abort, div_start, ex_div_valid}); end
        step();
        idle_inputs();
    endtask

    task automatic test_cancel_vs_ready();
        ex_div_request = 1'b1;
        step();
        step();
        step();
        div_cancel = 1'b1;
        div_ready  = 1'b1;
        div_result = 64'h0bad_0bad_0bad_0bad;
        step();
        idle_inputs();
        #1;
        n_total++; if ({div_abort, ex_div_valid} !== 2'b10) begin n_bad++; $display("FAIL cancel_ready_abort got=%b want=10", {div_abort, ex_div_valid}); end
        step();
        n_total++; if ({ex_div_valid, ex_div_result} !== {1'b0, 32'd2, 32'd14}) begin n_bad++; $display("FAIL cancel_ready_result got=%b/%h want=0/%h", ex_div_valid, ex_div_result, {32'd2, 32'd14}); end
    endtask

    task automatic test_back_to_back();
        ex_div_request = 1'b1;
        ex_div_signed  = 1'b1;
        ex_div_opa     = 32'd20;
        ex_div_opb     = 32'd6;
        step();
        step();
        div_ready  = 1'b1;
        div_result = {32'd2, 32'd3};
        step();
        div_ready     = 1'b0;
        ex_div_signed = 1'b0;
        ex_div_opa    = 32'd50;
        ex_div_opb    = 32'd5;
        n_total++; if ({ex_div_valid, ex_div_result} !== {1'b1, 32'd2, 32'd3}) begin n_bad++; $display("FAIL b2b_first got=%b/%h want=1/%h", ex_div_valid, ex_div_result, {32'd2, 32'd3}); end
        step();
        n_total++; if ({div_start, ex_div_valid, stall} !== {2'b00, 6'b001111}) begin n_bad++; $display("FAIL b2b_gap got=%b want=00001111", {div_start, ex_div_valid, stall}); end
        step();
        n_total++; if ({div_start, div_signed, div_opa, div_opb} !== {2'b10, 32'd50, 32'd5}) begin n_bad++; $display("FAIL b2b_second_start got=%b/%b/%0d/%0d want=1/0/50/5", div_start, div_signed, div_opa, div_opb); end
        step();
        div_ready  = 1'b1;
        div_result = {32'd0, 32'd10};
        step();
        div_ready      = 1'b0;
        ex_div_request = 1'b0;
        n_total++; if ({ex_div_valid, ex_div_result} !== {1'b1, 32'd0, 32'd10}) begin n_bad++; $display("FAIL b2b_second got=%b/%h want=1/%h", ex_div_valid, ex_div_result, {32'd0, 32'd10}); end
        step();
        idle_inputs();
    endtask

    task automatic test_reset_mid_divide();
        ex_div_request = 1'b1;
        ex_div_opa     = 32'd77;
        ex_div_opb     = 32'd11;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        ex_div_request = 1'b0;
        #1;
        n_total++; if ({div_abort, div_start, ex_div_valid, div_opa, ex_div_result} !== 99'd0) begin n_bad++; $display("FAIL reset_mid got abort=%b start=%b valid=%b opa=%0d res=%h want all 0", div_abort, div_start, ex_div_valid, div_opa, ex_div_result); end
        reset = 1'b0;
        step();
        n_total++; if ({div_abort, stall} !== 7'd0) begin n_bad++; $display("FAIL reset_mid_after got=%b want=0", {div_abort, stall}); end
        idle_inputs();
    endtask

    task automatic test_watchdog();
        ex_div_request = 1'b1;
        step();
        step();
`ifdef DIV_WATCHDOG_EN
        repeat (35) step();
        n_total++; if ({div_error, ex_div_valid, stall[3]} !== 3'b001) begin n_bad++; $display("FAIL wd_before got=%b want=001", {div_error, ex_div_valid, stall[3]}); end
        step();
        n_total++; if ({div_error, div_abort, ex_div_valid, ex_div_result} !== {3'b111, 64'd0}) begin n_bad++; $display("FAIL wd_expire got err=%b abort=%b valid=%b res=%h want 1/1/1/0", div_error, div_abort, ex_div_valid, ex_div_result); end
        ex_div_request = 1'b0;
        step();
        n_total++; if ({div_error, div_abort, ex_div_valid} !== 3'b000) begin n_bad++; $display("FAIL wd_pulse got=%b want=000", {div_error, div_abort, ex_div_valid}); end
`else
        repeat (50) begin
            n_total++; if ({div_error, div_abort, ex_div_valid, stall[3]} !== 4'b0001) begin n_bad++; $display("FAIL nowd_wait got=%b want=0001", {div_error, div_abort, ex_div_valid, stall[3]}); end
            step();
        end
        div_ready  = 1'b1;
        div_result = {32'd5, 32'd6};
        step();
        div_ready      = 1'b0;
        ex_div_request = 1'b0;
        n_total++; if ({ex_div_valid, div_error, ex_div_result} !== {2'b10, 32'd5, 32'd6}) begin n_bad++; $display("FAIL nowd_done got=%b/%b/%h want=1/0/%h", ex_div_valid, div_error, ex_div_result, {32'd5, 32'd6}); end
        step();
`endif
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_stall_merge();
        test_divide();
        test_ready_ignored();
        test_cancel_busy();
        test_cancel_start();
        test_cancel_vs_ready();
        test_back_to_back();
        test_reset_mid_divide();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
